// File: rtl/response_fault_injector.sv
// rtl/response_fault_injector.sv - one-cycle PSL response register with windowed response-code replacement (feature macro RESPONSE_INJECT_EN)
module response_fault_injector #(
  parameter  int NUM_WINDOWS = 4,
  parameter  int COUNT_WIDTH = 16,
  localparam int IDX_W       = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1
) (
  input  logic                   clock,
  input  logic                   rstn_in,
  input  logic                   enabled_in,
  input  logic                   clear_in,
  input  logic                   response_in_valid,
  input  logic [7:0]             response_in_tag,
  input  logic                   response_in_tagpar,
  input  logic [7:0]             response_in_response,
  input  logic [8:0]             response_in_credits,
  input  logic [1:0]             response_in_cache_state,
  input  logic [12:0]            response_in_cache_pos,
  output logic                   response_out_valid,
  output logic [7:0]             response_out_tag,
  output logic                   response_out_tagpar,
  output logic [7:0]             response_out_response,
  output logic [8:0]             response_out_credits,
  output logic [1:0]             response_out_cache_state,
  output logic [12:0]            response_out_cache_pos,
  input  logic                   cfg_valid,
  input  logic [IDX_W-1:0]       cfg_index,
  input  logic [1:0]             cfg_mode,
  input  logic [COUNT_WIDTH-1:0] cfg_start,
  input  logic [COUNT_WIDTH-1:0] cfg_end,
  input  logic [7:0]             cfg_code,
  output logic                   injected_out,
  output logic [COUNT_WIDTH-1:0] response_count,
  output logic [31:0]            inject_count
);

  logic        r_valid;
  logic [7:0]  r_tag;
  logic        r_tagpar;
  logic [7:0]  r_response;
  logic [8:0]  r_credits;
  logic [1:0]  r_cache_state;
  logic [12:0] r_cache_pos;
  logic [7:0]  w_code_next;

  // Response register: every field is delayed one cycle, only the code may be substituted.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      r_valid       <= 1'b0;
      r_tag         <= 8'h00;
      r_tagpar      <= 1'b0;
      r_response    <= 8'h00;
      r_credits     <= 9'h000;
      r_cache_state <= 2'b00;
      r_cache_pos   <= 13'h0000;
    end else begin
      r_valid       <= response_in_valid;
      r_tag         <= response_in_tag;
      r_tagpar      <= response_in_tagpar;
      r_response    <= w_code_next;
      r_credits     <= response_in_credits;
      r_cache_state <= response_in_cache_state;
      r_cache_pos   <= response_in_cache_pos;
    end
  end

  assign response_out_valid       = r_valid;
  assign response_out_tag         = r_tag;
  assign response_out_tagpar      = r_tagpar;
  assign response_out_response    = r_response;
  assign response_out_credits     = r_credits;
  assign response_out_cache_state = r_cache_state;
  assign response_out_cache_pos   = r_cache_pos;

`ifdef RESPONSE_INJECT_EN
  localparam logic [7:0] PAGED = 8'h0A;

  logic [1:0]             r_mode     [NUM_WINDOWS];
  logic [COUNT_WIDTH-1:0] r_start    [NUM_WINDOWS];
  logic [COUNT_WIDTH-1:0] r_end      [NUM_WINDOWS];
  logic [7:0]             r_win_code [NUM_WINDOWS];
  logic [COUNT_WIDTH-1:0] r_count;
  logic [31:0]            r_inject_count;
  logic                   r_injected;

  logic                   w_fire;
  logic [NUM_WINDOWS-1:0] w_match;
  logic                   w_hit;
  logic [7:0]             w_hit_code;
  logic                   w_replace;

  assign w_fire = response_in_valid & enabled_in;

  // Per-window comparison against the current index; uses the config held before any same-cycle write.
  always_comb begin
    w_match = '0;
    for (int w = 0; w < NUM_WINDOWS; w++) begin
      case (r_mode[w])
        2'b01:   w_match[w] = (r_count == r_start[w]);
        2'b10:   w_match[w] = (r_count >= r_start[w]) && (r_count <= r_end[w]);
        2'b11:   w_match[w] = (r_count >= r_start[w]) && (r_count <= r_end[w]) &&
                              (r_count[0] == r_start[w][0]);
        default: w_match[w] = 1'b0;
      endcase
    end
  end

  // Lowest-indexed matching window wins: scan downwards so the last assignment is the lowest.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_code = 8'h00;
    for (int w = NUM_WINDOWS - 1; w >= 0; w--) begin
      if (w_match[w]) begin
        w_hit      = 1'b1;
        w_hit_code = r_win_code[w];
      end
    end
  end

  // A genuine PAGED is left alone so the AFU resume sequence is not broken.
  assign w_replace   = w_fire & w_hit & (response_in_response != PAGED);
  assign w_code_next = w_replace ? w_hit_code : response_in_response;

  // Window config storage; indices at or above NUM_WINDOWS match no slot and are dropped.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      for (int w = 0; w < NUM_WINDOWS; w++) begin
        r_mode[w]     <= 2'b00;
        r_start[w]    <= '0;
        r_end[w]      <= '0;
        r_win_code[w] <= 8'h00;
      end
    end else begin
      for (int w = 0; w < NUM_WINDOWS; w++) begin
        if (cfg_valid && (cfg_index == IDX_W'(w))) begin
          r_mode[w]     <= cfg_mode;
          r_start[w]    <= cfg_start;
          r_end[w]      <= cfg_end;
          r_win_code[w] <= cfg_code;
        end
      end
    end
  end

  // Response index and replacement statistics; clear wins over the increment of the same cycle.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      r_count        <= '0;
      r_inject_count <= 32'h0000_0000;
      r_injected     <= 1'b0;
    end else begin
      if (clear_in) begin
        r_count <= '0;
      end else if (w_fire && (r_count != '1)) begin
        r_count <= r_count + COUNT_WIDTH'(1);
      end
      if (w_replace && (r_inject_count != 32'hFFFF_FFFF)) begin
        r_inject_count <= r_inject_count + 32'd1;
      end
      r_injected <= w_replace;
    end
  end

  assign injected_out   = r_injected;
  assign response_count = r_count;
  assign inject_count   = r_inject_count;
`else
  logic w_unused_cfg;

  assign w_code_next    = response_in_response;
  assign w_unused_cfg   = ^{enabled_in, clear_in, cfg_valid, cfg_index, cfg_mode,
                            cfg_start, cfg_end, cfg_code};
  assign injected_out   = 1'b0;
  assign response_count = '0;
  assign inject_count   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_response_fault_injector.sv
// tb/tb_response_fault_injector.sv - randomized and directed bench for response_fault_injector against a behavioural model
module tb_response_fault_injector;
  localparam int NW = 5;
  localparam int CW = 16;
  localparam int IW = 3;
`ifdef RESPONSE_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif
  localparam logic [7:0] C_DONE    = 8'h00;
  localparam logic [7:0] C_AERROR  = 8'h01;
  localparam logic [7:0] C_DERROR  = 8'h03;
  localparam logic [7:0] C_FLUSHED = 8'h06;
  localparam logic [7:0] C_FAULT   = 8'h07;
  localparam logic [7:0] C_PAGED   = 8'h0A;

  logic clock = 1'b0;
  logic rstn_in = 1'b0;
  logic enabled_in = 1'b0;
  logic clear_in = 1'b0;
  logic        ri_valid = 1'b0;
  logic [7:0]  ri_tag = 8'h00;
  logic        ri_tagpar = 1'b0;
  logic [7:0]  ri_resp = 8'h00;
  logic [8:0]  ri_credits = 9'h000;
  logic [1:0]  ri_cs = 2'b00;
  logic [12:0] ri_cp = 13'h0000;
  logic        ro_valid;
  logic [7:0]  ro_tag;
  logic        ro_tagpar;
  logic [7:0]  ro_resp;
  logic [8:0]  ro_credits;
  logic [1:0]  ro_cs;
  logic [12:0] ro_cp;
  logic          cfg_valid = 1'b0;
  logic [IW-1:0] cfg_index = '0;
  logic [1:0]    cfg_mode = 2'b00;
  logic [CW-1:0] cfg_start = '0;
  logic [CW-1:0] cfg_end = '0;
  logic [7:0]    cfg_code = 8'h00;
  logic          injected_out;
  logic [CW-1:0] response_count;
  logic [31:0]   inject_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  int         m_mode  [NW];
  int         m_start [NW];
  int         m_end   [NW];
  logic [7:0] m_code  [NW];
  int         m_k;
  longint     m_inj;

  response_fault_injector #(.NUM_WINDOWS(NW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in), .clear_in(clear_in),
    .response_in_valid(ri_valid), .response_in_tag(ri_tag), .response_in_tagpar(ri_tagpar),
    .response_in_response(ri_resp), .response_in_credits(ri_credits),
    .response_in_cache_state(ri_cs), .response_in_cache_pos(ri_cp),
    .response_out_valid(ro_valid), .response_out_tag(ro_tag), .response_out_tagpar(ro_tagpar),
    .response_out_response(ro_resp), .response_out_credits(ro_credits),
    .response_out_cache_state(ro_cs), .response_out_cache_pos(ro_cp),
    .cfg_valid(cfg_valid), .cfg_index(cfg_index), .cfg_mode(cfg_mode), .cfg_start(cfg_start),
    .cfg_end(cfg_end), .cfg_code(cfg_code),
    .injected_out(injected_out), .response_count(response_count), .inject_count(inject_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_mode[w] = 0; m_start[w] = 0; m_end[w] = 0; m_code[w] = 8'h00;
    end
    m_k = 0;
    m_inj = 0;
  endtask

  function automatic bit window_hits(int w, int k);
    case (m_mode[w])
      1:       return k == m_start[w];
      2:       return (k >= m_start[w]) && (k <= m_end[w]);
      3:       return (k >= m_start[w]) && (k <= m_end[w]) && (((k - m_start[w]) % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    ri_valid = 1'b0; enabled_in = 1'b0; clear_in = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_resp"}, 64'({ro_valid, ro_tag, ro_tagpar, ro_resp, ro_credits, ro_cs, ro_cp}), 64'd0);
    check({tag, "_injected"}, 64'(injected_out), 64'd0);
    check({tag, "_resp_count"}, 64'(response_count), 64'd0);
    check({tag, "_inj_count"}, 64'(inject_count), 64'd0);
  endtask

  // One clock: drive inputs, advance the model, then compare the registered outputs.
  task automatic step(input bit v, input bit en, input logic [7:0] tag, input logic [7:0] code,
                      input bit clr, input bit cfg, input int ci, input int mi, input int si,
                      input int ei, input logic [7:0] cc);
    logic [7:0] exp_code;
    bit         exp_inj;
    int         hitw;
    ri_valid = v; ri_tag = tag; ri_tagpar = ~^tag; ri_resp = code;
    ri_credits = 9'($urandom); ri_cs = 2'($urandom); ri_cp = 13'($urandom);
    enabled_in = en; clear_in = clr;
    cfg_valid = cfg; cfg_index = IW'(ci); cfg_mode = 2'(mi);
    cfg_start = CW'(si); cfg_end = CW'(ei); cfg_code = cc;
    exp_code = code;
    exp_inj = 1'b0;
    if (INJ && v && en) begin
      hitw = -1;
      for (int w = 0; w < NW; w++) if (hitw < 0 && window_hits(w, m_k)) hitw = w;
      if (hitw >= 0 && code != C_PAGED) begin
        exp_code = m_code[hitw];
        exp_inj = 1'b1;
        if (m_inj < 64'hFFFF_FFFF) m_inj++;
      end
      if (m_k < (1 << CW) - 1) m_k++;
    end
    if (INJ && clr) m_k = 0;
    if (INJ && cfg && ci < NW) begin
      m_mode[ci] = mi; m_start[ci] = si; m_end[ci] = ei; m_code[ci] = cc;
    end
    @(posedge clock);
    #1;
    check("resp", 64'({ro_valid, ro_tag, ro_tagpar, ro_resp, ro_credits, ro_cs, ro_cp}),
          64'({v, tag, ~^tag, exp_code, ri_credits, ri_cs, ri_cp}));
    check("injected", 64'(injected_out), 64'(exp_inj));
    check("resp_count", 64'(response_count), 64'(m_k));
    check("inj_count", 64'(inject_count), 64'(m_inj[31:0]));
    pulses += int'(injected_out);
  endtask

  task automatic resp(input int idx, input logic [7:0] code);
    step(1'b1, 1'b1, 8'(idx), code, 1'b0, 1'b0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic cfg_win(input int ci, input int mi, input int si, input int ei, input logic [7:0] cc);
    step(1'b0, 1'b1, 8'h00, C_DONE, 1'b0, 1'b1, ci, mi, si, ei, cc);
  endtask

  task automatic clear_idle();
    step(1'b0, 1'b1, 8'h00, C_DONE, 1'b1, 1'b0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    model_reset();
    // Reset state while inputs toggle
    ri_valid = 1'b1; enabled_in = 1'b1; ri_tag = 8'h5A; ri_resp = C_FAULT; cfg_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    idle_inputs();
    @(negedge clock);
    rstn_in = 1'b1;
    @(posedge clock);
    #1;

    // Pass-through
    for (int i = 0; i < 300; i++) resp(i, C_DONE);
    check("pass_resp_count", 64'(response_count), INJ ? 64'd300 : 64'd0);
    check("pass_inj_count", 64'(inject_count), 64'd0);

    // Single window at 234 injecting PAGED
    cfg_win(0, 1, 234, 0, C_PAGED);
    clear_idle();
    pulses = 0;
    for (int i = 0; i < 300; i++) resp(i, C_DONE);
    check("single_pulses", 64'(pulses), INJ ? 64'd1 : 64'd0);
    check("single_inj_count", 64'(inject_count), INJ ? 64'd1 : 64'd0);

    // Overlapping windows with a genuine PAGED inside the range
    cfg_win(0, 2, 190, 199, C_FAULT);
    cfg_win(1, 2, 185, 195, C_FLUSHED);
    clear_idle();
    pulses = 0;
    for (int i = 0; i < 210; i++) resp(i, (i == 192) ? C_PAGED : C_DONE);
    check("overlap_pulses", 64'(pulses), INJ ? 64'd14 : 64'd0);
    check("overlap_inj_count", 64'(inject_count), INJ ? 64'd15 : 64'd0);

    // Range-alternate and empty range
    cfg_win(0, 0, 0, 0, 8'h00);
    cfg_win(1, 0, 0, 0, 8'h00);
    cfg_win(2, 3, 30, 37, C_DERROR);
    cfg_win(3, 2, 50, 40, C_AERROR);
    clear_idle();
    pulses = 0;
    for (int i = 0; i < 60; i++) resp(i, C_DONE);
    check("alt_pulses", 64'(pulses), INJ ? 64'd4 : 64'd0);

    // Config write in the same cycle as the targeted response
    cfg_win(2, 0, 0, 0, 8'h00);
    cfg_win(3, 0, 0, 0, 8'h00);
    clear_idle();
    pulses = 0;
    for (int i = 0; i < 10; i++) resp(i, C_DONE);
    step(1'b1, 1'b1, 8'd10, C_DONE, 1'b0, 1'b1, 0, 1, 10, 0, C_AERROR);
    check("samecfg_pulses", 64'(pulses), 64'd0);
    step(1'b1, 1'b1, 8'd11, C_DONE, 1'b1, 1'b0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i <= 10; i++) resp(i, C_DONE);
    check("recount_pulses", 64'(pulses), INJ ? 64'd1 : 64'd0);
    // Clear together with a matching response: evaluated at old index, then restart at 0
    clear_idle();
    for (int i = 0; i < 10; i++) resp(i, C_DONE);
    step(1'b1, 1'b1, 8'd10, C_DONE, 1'b1, 1'b0, 0, 0, 0, 0, 8'h00);
    check("clear_same_pulses", 64'(pulses), INJ ? 64'd2 : 64'd0);
    resp(0, C_DONE);
    check("clear_next_count", 64'(response_count), INJ ? 64'd1 : 64'd0);

    // Randomized traffic with random config, clears and enable gaps
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] rc;
      case ($urandom_range(0, 3))
        0: rc = C_DONE;
        1: rc = C_PAGED;
        2: rc = C_FLUSHED;
        default: rc = 8'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 8'($urandom), rc,
           $urandom_range(0, 30) == 0, $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 30)), int'($urandom_range(0, 40)), 8'($urandom));
    end

    // Asynchronous reset mid-stream, then confirm windows come back off
    cfg_win(0, 2, 0, 50, C_FAULT);
    resp(0, C_DONE);
    rstn_in = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    idle_inputs();
    @(negedge clock);
    rstn_in = 1'b1;
    @(posedge clock);
    #1;
    pulses = 0;
    for (int i = 0; i < 40; i++) resp(i, C_DONE);
    check("postreset_pulses", 64'(pulses), 64'd0);
    check("postreset_count", 64'(response_count), INJ ? 64'd40 : 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
